// File: rtl/fifo_pkg.sv
// Shared types for the FIFO read-side drain engine.
package fifo_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } rd_state_t;

  typedef enum logic [1:0] {
    LD_NONE = 2'd0,
    LD_FIFO = 2'd1,
    LD_SKID = 2'd2
  } main_ld_t;

endpackage

// File: rtl/fifo_stream_reader.sv
// Drains a show-ahead FIFO into a registered valid/ready stream through a
// 2-entry skid buffer so the FIFO pop never depends on downstream ready.
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_r_data,
  output logic                  fifo_rd,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic [CNT_WIDTH-1:0]  word_count
);

  rd_state_t             state_q, state_d;
  main_ld_t              main_ld;
  logic                  skid_ld;
  logic                  push, pop;
  logic                  vld_p1;
  logic [DATA_WIDTH-1:0] main_p1, skid_p1;
  logic [CNT_WIDTH-1:0]  cnt_q;

  assign pop = vld_p1 & m_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = EMPTY;
    case (state_q)
      EMPTY:   state_d = push ? ONE : EMPTY;
      ONE: begin
        if (push && !pop)      state_d = TWO;
        else if (!push && pop) state_d = EMPTY;
        else                   state_d = ONE;
      end
      TWO:     state_d = pop ? ONE : TWO;
      default: state_d = EMPTY;
    endcase
  end

  // Pop strobe looks only at registered state, enable and empty; gated off in reset.
  always_comb begin
    push    = 1'b0;
    main_ld = LD_NONE;
    skid_ld = 1'b0;
    case (state_q)
      EMPTY, ONE: push = reset & enable & ~fifo_empty;
      default:    push = 1'b0;
    endcase
    case (state_q)
      EMPTY: if (push) main_ld = LD_FIFO;
      ONE: begin
        if (push && pop) main_ld = LD_FIFO;
        else if (push)   skid_ld = 1'b1;
      end
      TWO:   if (pop) main_ld = LD_SKID;
      default: main_ld = LD_NONE;
    endcase
  end

  // Output stage: main/skid words, stream valid and delivered-word counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p1  <= 1'b0;
      main_p1 <= '0;
      skid_p1 <= '0;
      cnt_q   <= '0;
    end else begin
      vld_p1 <= (state_d != EMPTY);
      case (main_ld)
        LD_FIFO: main_p1 <= fifo_r_data;
        LD_SKID: main_p1 <= skid_p1;
        default: main_p1 <= main_p1;
      endcase
      if (skid_ld) skid_p1 <= fifo_r_data;
      if (pop)     cnt_q   <= cnt_q + CNT_WIDTH'(1);
    end
  end

  assign fifo_rd    = push;
  assign m_valid    = vld_p1;
  assign m_data     = main_p1;
  assign word_count = cnt_q;

endmodule
